store_buffer: RTL
=================

// Module: store_buffer
// PURPOSE
// - Write-side companion to the load path: queues stores from execute and drains them to the data-memory write port.
// - Aligns byte/half/word store data onto 32-bit lanes and generates byte enables.
// - Holds each write stable until memory accepts it, so execute never stalls on a slow write port unless the queue is full.
// PARAMETERS
// - DATA_WIDTH   32  store data / memory word width (fixed 32 for lane logic)
// - MEM_AW       32  byte address width
// - DEPTH         4  queue entries, power of two, >=2
// PORTS
// - clk        in   1       rising-edge clock
// - rst_n      in   1       synchronous, active-low reset
// - st_valid   in   1       store request from execute
// - st_ready   out  1       buffer can accept (= !full)
// - st_addr    in   MEM_AW  byte address
// - st_data    in   32      rs2 value, data in low bits
// - st_size    in   2       00 byte, 01 half, 10 word, 11 reserved
// - misalign   out  1       1-cycle pulse: accepted request was dropped
// - mem_we     out  1       write request to data memory
// - mem_ready  in   1       memory accepts write this cycle
// - mem_addr   out  MEM_AW  word-aligned address ([1:0]=0)
// - mem_wdata  out  32      lane-aligned data
// - mem_be     out  4       byte enables
// - ld_addr    in   MEM_AW  load address for forwarding check
// - fwd_hit    out  1       buffered store overlaps ld_addr word
// - fwd_data   out  32      lane-aligned data of youngest matching entry
// - fwd_be     out  4       byte enables of that entry
// - count      out  $clog2(DEPTH)+1  occupied entries
// - empty      out  1       count==0
// BEHAVIOUR
// - Reset: count=0, mem_we=0, misalign=0, fwd_hit=0, mem_addr/mem_wdata/mem_be=0; pointers 0; entries discarded.
// - Push on clk edge when st_valid&&st_ready; aligned data/be computed at push time and stored.
// - Lane rules (off=addr[1:0]): byte be=4'b0001<<off, data={4{d[7:0]}}; half be=4'b0011<<off, data={2{d[15:0]}};
//   word be=4'b1111, data=d.
// - Misaligned (half with off[0]=1, word with off!=0, or size 11): handshake completes, entry NOT queued,
//   misalign=1 the following cycle only.
// - Drain FSM: IDLE (mem_we=0) -> WRITE when count!=0; WRITE drives head entry, mem_we=1;
//   on edge with mem_ready=1 pop head; stay WRITE if entries remain else IDLE.
// - Latency: store pushed at edge N into empty buffer -> mem_we=1 during cycle N+1.
// - mem_addr/mem_wdata/mem_be stable while mem_we=1 && !mem_ready.
// - Simultaneous push and pop: count unchanged; allowed at any level including full (st_ready still
//   reflects full at start of cycle; no same-cycle pass-through).
// - Full: st_ready=0; st_valid ignored. Pointers wrap modulo DEPTH.
// - rst_n low mid-write: mem_we drops next edge; in-flight write abandoned.
// - Stores drain strictly in order; no merging.
// CONFIGURATION
// - STORE_BUF_FWD_EN defined: fwd_* combinational; search all valid entries (including head in WRITE)
//   for addr[MEM_AW-1:2]==ld_addr[MEM_AW-1:2]; youngest match wins; fwd_hit=1.
// - Undefined: fwd_hit=0, fwd_data=0, fwd_be=0; ports retained; no compare logic.
// STRUCTURE
// - store_buf_pkg: size enum (SZ_BYTE/SZ_HALF/SZ_WORD), entry struct {addr, data, be},
//   drain-state enum, function lane_align().
// - Sub-module sb_align: combinational size/offset -> {data, be, misaligned}; instanced once on push path.
// TESTING
// - Reset: rst_n=0 with 3 entries queued -> next cycle count=0, mem_we=0, empty=1.
// - sb at 0x103 data 0xAB, mem_ready=1 -> mem_addr=0x100, be=1000, wdata=0xABABABAB, one cycle later.
// - 5 words with DEPTH=4, mem_ready=0 -> st_ready=0 after 4; raise mem_ready -> written in order, 5th accepted.
// - sh at 0x201 -> misalign pulse, count unchanged, no mem_we.
// - mem_ready toggling 0/1 -> mem_* stable during stalls, each entry written once.
// - FWD_EN: sw 0x300=0x11, sb 0x302=0x22, ld_addr=0x300 -> fwd_hit=1, fwd_be=0100, fwd_data=0x22222222.

Source files
------------

// File: rtl/store_buf_pkg.sv
// store_buf_pkg
//   Shared types for the store buffer: store size encoding, queued entry
//   layout, drain state encoding and the lane alignment helper used on the
//   push path.
package store_buf_pkg;

  localparam int SB_DW = 32;
  localparam int SB_AW = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // One queued write: word-aligned address, lane-aligned data, byte enables.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
    logic [3:0]       be;
  } sb_entry_t;

  typedef enum logic {
    DRAIN_IDLE  = 1'b0,
    DRAIN_WRITE = 1'b1
  } drain_state_e;

  typedef struct packed {
    logic [SB_DW-1:0] data;
    logic [3:0]       be;
    logic             misaligned;
  } lane_t;

  // Replicates the low bytes of the store value across all lanes so that
  // whichever lane the byte enables select already carries the right bytes.
  function automatic lane_t lane_align(input logic [1:0] size,
                                       input logic [1:0] off,
                                       input logic [SB_DW-1:0] d);
    lane_t r;
    r = '0;
    case (size)
      SZ_BYTE: begin
        r.data = {4{d[7:0]}};
        r.be   = 4'b0001 << off;
      end
      SZ_HALF: begin
        r.data       = {2{d[15:0]}};
        r.be         = 4'b0011 << off;
        r.misaligned = off[0];
      end
      SZ_WORD: begin
        r.data       = d;
        r.be         = 4'b1111;
        r.misaligned = (off != 2'b00);
      end
      default: begin
        r.misaligned = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if
//   Bundles the execute-side store handshake, the data-memory write port and
//   the load forwarding lookup of the store buffer.
//   slave  : seen by store_buffer (takes st_*, mem_ready, ld_addr)
//   master : seen by the surrounding pipeline / memory model
interface store_buffer_if #(
  parameter int MEM_AW     = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  st_valid;
  logic                  st_ready;
  logic [MEM_AW-1:0]     st_addr;
  logic [DATA_WIDTH-1:0] st_data;
  logic [1:0]            st_size;
  logic                  misalign;

  logic                  mem_we;
  logic                  mem_ready;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_be;

  logic [MEM_AW-1:0]     ld_addr;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [3:0]            fwd_be;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready, ld_addr,
    output st_ready, misalign, mem_we, mem_addr, mem_wdata, mem_be,
           fwd_hit, fwd_data, fwd_be
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready, ld_addr,
    input  st_ready, misalign, mem_we, mem_addr, mem_wdata, mem_be,
           fwd_hit, fwd_data, fwd_be
  );

endinterface

// File: rtl/sb_align.sv
// sb_align
//   Combinational store alignment: turns size + byte offset + raw store value
//   into lane-aligned data, byte enables and a misalignment flag.
//   size       in  2   store size code
//   off        in  2   byte offset inside the word
//   din        in  32  store value, data in low bits
//   dout       out 32  lane-aligned data
//   be         out 4   byte enables
//   misaligned out 1   request cannot be performed as one word write
module sb_align
  import store_buf_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       off,
  input  logic [SB_DW-1:0] din,
  output logic [SB_DW-1:0] dout,
  output logic [3:0]       be,
  output logic             misaligned
);

  lane_t lane;

  // All alignment rules live in the package helper so the rules exist once.
  always_comb begin
    lane       = lane_align(size, off, din);
    dout       = lane.data;
    be         = lane.be;
    misaligned = lane.misaligned;
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Queues stores from execute and drains them in order to the data-memory
//   write port, holding each write stable until memory accepts it.
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of store_buffer_if (store handshake, memory write
//          port, forwarding lookup)
//   count  out  occupied entries
//   empty  out  count == 0
//   Optional feature: define STORE_BUF_FWD_EN to enable load forwarding.
//   Without it fwd_hit/fwd_data/fwd_be are tied to zero.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 32,
  parameter int DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  store_buffer_if.slave          bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [0:0] S_IDLE  = 1'(DRAIN_IDLE);
  localparam logic [0:0] S_WRITE = 1'(DRAIN_WRITE);

  sb_entry_t        entries [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic [PW:0]      cnt_next;
  logic [0:0]       state;

  logic             full;
  logic             accept;
  logic             push;
  logic             pop;
  logic [SB_DW-1:0] al_data;
  logic [3:0]       al_be;
  logic             al_mis;
  sb_entry_t        new_entry;

  sb_align u_align (
    .size       (bus.st_size),
    .off        (bus.st_addr[1:0]),
    .din        (SB_DW'(bus.st_data)),
    .dout       (al_data),
    .be         (al_be),
    .misaligned (al_mis)
  );

  // A misaligned request still completes its handshake but is never queued.
  assign full         = (cnt == FULL_CNT);
  assign bus.st_ready = !full;
  assign accept       = bus.st_valid && !full;
  assign push         = accept && !al_mis;
  assign pop          = (state == S_WRITE) && bus.mem_ready;

  assign new_entry.addr = SB_AW'({bus.st_addr[MEM_AW-1:2], 2'b00});
  assign new_entry.data = al_data;
  assign new_entry.be   = al_be;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    cnt_next = cnt;
    if (push && !pop) begin
      cnt_next = cnt + 1'b1;
    end else if (!push && pop) begin
      cnt_next = cnt - 1'b1;
    end
  end

  // Entry storage needs no reset: only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= new_entry;
    end
  end

  // Pointers, occupancy, drain state and the misalign pulse. The drain state
  // looks at next occupancy so a push into an empty buffer is written the
  // very next cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      state        <= S_IDLE;
      bus.misalign <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt          <= cnt_next;
      state        <= (cnt_next != '0) ? S_WRITE : S_IDLE;
      bus.misalign <= accept && al_mis;
    end
  end

  // Head entry is presented only while writing; it cannot change until popped.
  always_comb begin
    bus.mem_we    = (state == S_WRITE);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_be    = '0;
    if (state == S_WRITE) begin
      bus.mem_addr  = MEM_AW'(entries[rd_ptr].addr);
      bus.mem_wdata = DATA_WIDTH'(entries[rd_ptr].data);
      bus.mem_be    = entries[rd_ptr].be;
    end
  end

  assign count = cnt;
  assign empty = (cnt == '0);

`ifdef STORE_BUF_FWD_EN
  logic [PW-1:0] fidx;

  // Walk oldest to youngest so the youngest matching entry is the last one
  // written into the result.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    bus.fwd_be   = '0;
    fidx         = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < cnt) &&
          (entries[fidx].addr[SB_AW-1:2] == bus.ld_addr[MEM_AW-1:2])) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = DATA_WIDTH'(entries[fidx].data);
        bus.fwd_be   = entries[fidx].be;
      end
    end
  end
`else
  logic unused_ld_addr;

  assign unused_ld_addr = ^bus.ld_addr;
  assign bus.fwd_hit    = 1'b0;
  assign bus.fwd_data   = '0;
  assign bus.fwd_be     = '0;
`endif

endmodule
